// File: rtl/cache_pkg.sv
// Shared geometry, FSM encoding and address helpers for the direct-mapped read cache.
package cache_pkg;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned INDEX_W   = 10;
  localparam int unsigned OFFSET_W  = 2;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned NUM_LINES = 1 << INDEX_W;
  localparam int unsigned WORDS     = 1 << OFFSET_W;
  localparam int unsigned LINE_W    = WORD_W * WORDS;
  localparam int unsigned BLK_W     = ADDR_W - OFFSET_W;
  localparam int unsigned HIT_W     = 14;

  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MISS    = 3'd2,
    FILL    = 3'd3,
    RESPOND = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]   line,
                                                  input logic [OFFSET_W-1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/direct_mapped_cache_if.sv
// CPU-side request/response and memory-side block fetch signals of the cache.
interface direct_mapped_cache_if;
  import cache_pkg::*;

  logic                  cache_read;
  logic                  cache_write;
  logic [ADDR_W-1:0]     address;
  logic                  cache_ready;
  logic [WORD_W-1:0]     cache_data;
  logic [HIT_W-1:0]      hit_count;
  logic                  mem_read;
  logic [BLK_W-1:0]      mem_address;
  logic                  mem_ready;
  logic [LINE_W-1:0]     mem_data;

  // The cache itself.
  modport slave (
    input  cache_read, cache_write, address, mem_ready, mem_data,
    output cache_ready, cache_data, hit_count, mem_read, mem_address
  );

  // The environment: CPU plus main memory.
  modport master (
    output cache_read, cache_write, address, mem_ready, mem_data,
    input  cache_ready, cache_data, hit_count, mem_read, mem_address
  );

endinterface

// File: rtl/cache_arrays.sv
// Line storage: valid bits (cleared by reset), tag and data arrays, one write and one read port.
module cache_arrays
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a cleared valid bit masks their contents.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped cache: request FSM, saturating hit counter and block-fetch handshake.
module direct_mapped_cache
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  direct_mapped_cache_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [HIT_W-1:0]    hit_count_q, hit_count_d;
  logic [WORD_W-1:0]   cache_data_q, cache_data_d;
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                wr_en;
  logic                lookup_hit;

  // Writes are accepted on the bus but the cache is read-only.
  logic unused_write;
  assign unused_write = bus.cache_write;

  cache_arrays u_arrays (
    .clk      (clk),
    .rst      (rst),
    .rd_index (addr_index(req_addr_q)),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (addr_index(req_addr_q)),
    .wr_tag   (addr_tag(req_addr_q)),
    .wr_line  (fill_line_q)
  );

  assign lookup_hit = rd_valid && (rd_tag == addr_tag(req_addr_q));

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    hit_count_d  = hit_count_q;
    cache_data_d = cache_data_q;
    fill_line_d  = fill_line_q;
    wr_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cache_read) begin
          req_addr_d = bus.address;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          cache_data_d = line_word(rd_line, req_addr_q[OFFSET_W-1:0]);
          if (hit_count_q != HIT_MAX) begin
            hit_count_d = hit_count_q + {{(HIT_W-1){1'b0}}, 1'b1};
          end
          state_d = RESPOND;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (bus.mem_ready) begin
          fill_line_d = bus.mem_data;
          state_d     = FILL;
        end
      end
      FILL: begin
        wr_en        = 1'b1;
        cache_data_d = line_word(fill_line_q, req_addr_q[OFFSET_W-1:0]);
        state_d      = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      hit_count_q  <= '0;
      cache_data_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      hit_count_q  <= hit_count_d;
      cache_data_q <= cache_data_d;
    end
  end

  // Captured block only feeds the FILL write, which reset already blocks.
  always_ff @(posedge clk) begin
    fill_line_q <= fill_line_d;
  end

  assign bus.cache_ready = (state_q == RESPOND);
  assign bus.cache_data  = cache_data_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.mem_read    = (state_q == MISS);
  assign bus.mem_address = req_addr_q[ADDR_W-1:OFFSET_W];

endmodule
